led_mode_sequencer: RTL and testbench
=====================================

# led_mode_sequencer

Controller that sequences the LED blinker's rate configuration. It drives the blinker's enable and two rate-select inputs from a single raw pushbutton, and optionally auto-advances through the blink rates on a programmable dwell timer. It sits between the board pushbutton/switch and the blinker instance in the top level. All outputs are registered, so the blinker sees glitch-free configuration changes.

## Interface
- c_DEBOUNCE_COUNT, default 250000: consecutive stable cycles required before a button level change is accepted; must be ≥2.
- c_DWELL_COUNT, default 25000000: cycles each rate is held in auto mode; must be ≥2.
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_button  input  1  raw pushbutton, active-high, asynchronous to i_clk, bouncy.
- i_auto  input  1  level; 1 = auto-advance mode, 0 = manual mode.
- o_enable  output  1  to blinker enable.
- o_select0  output  1  to blinker select0 (LSB).
- o_select1  output  1  to blinker select1 (MSB).
- o_mode  output  3  current state index: 0=OFF, 1=1Hz, 2=5Hz, 3=10Hz, 4=20Hz.

## Operation
- States (o_mode / o_enable / {o_select1,o_select0}):
  - OFF: 0 / 0 / 00
  - R1: 1 / 1 / 00
  - R5: 2 / 1 / 01
  - R10: 3 / 1 / 10
  - R20: 4 / 1 / 11
- Button path:
  - Two-flop synchronizer (s1, s2).
  - Debounce counter compares s2 against the debounced level deb.
    - s2 == deb: counter cleared to 0.
    - s2 != deb and counter == c_DEBOUNCE_COUNT-1: deb <= s2, counter cleared.
    - Otherwise the counter increments.
  - Step pulse = deb & ~deb_d, where deb_d is deb delayed one cycle. Exactly one step per accepted press; release generates nothing.
- Manual mode (i_auto=0): each step advances OFF→R1→R5→R10→R20→OFF. The dwell counter is held at 0.
- Auto mode (i_auto=1):
  - In OFF, the state moves to R1 on the next edge, with no step required.
  - In rate states, the dwell counter increments each cycle. At c_DWELL_COUNT-1 the state advances and the counter clears.
  - Auto sequence is R1→R5→R10→R20→R1; OFF is never re-entered.
  - A step also advances with the same wrap, skipping OFF, and clears the dwell counter.
- Step and dwell expiry in the same cycle: exactly one advance; the dwell counter clears.
- i_auto falling: the state holds its current value and the dwell counter clears to 0. i_auto rising: dwell starts from 0.
- Width: dwell counter is ceil(log2(c_DWELL_COUNT)) bits; debounce counter is ceil(log2(c_DEBOUNCE_COUNT)) bits. Neither counter ever exceeds its terminal value.

## Timing
- Reset (i_rst high at an edge): on that edge, state=OFF and all outputs are 0 (o_enable=0, o_select0=0, o_select1=0, o_mode=0). s1, s2, deb, deb_d and both counters are also cleared to 0.
- Reset mid-operation aborts any partial debounce or dwell count; there is no other recovery behaviour.
- The button is accepted during reset release; a press held across reset is debounced afresh from 0.
- Button latency: take edge 0 as the first edge that samples i_button=1 into s1, with the button held stable.
  - deb rises after edge c_DEBOUNCE_COUNT+1.
  - Outputs update on edge c_DEBOUNCE_COUNT+2.
- A pulse (post-sync) shorter than c_DEBOUNCE_COUNT cycles is ignored.
- Auto mode: each rate state is held for exactly c_DWELL_COUNT cycles of o_mode stability. The entry from OFF takes 1 cycle.
- Outputs change only on i_clk edges; all outputs update on the same edge, with no partial-update cycle.

## Test plan
Bench parameters: c_DEBOUNCE_COUNT=4, c_DWELL_COUNT=10, 10 ns clock.
- **Reset:** random state, then i_rst=1 for 2 cycles → o_enable=0, selects=00, o_mode=0, held while i_rst=1.
- **Manual single press:** i_auto=0, i_button=1 for 8 cycles → on edge 6 after the first sample, o_mode=1, o_enable=1, selects=00. No further change until the button is released and pressed again.
- **Glitch rejection:** i_button=1 for 3 cycles, then 0 with bouncing 1-0-1 pulses → o_mode stays 0.
- **Manual full cycle:** 5 clean presses → o_mode 1,2,3,4,0 with {sel1,sel0}=00,01,10,11, then o_enable=0 on the fifth press.
- **Auto sequence:** from OFF, i_auto=1 → o_mode=1 one edge later, then 2,3,4,1 every 10 cycles; OFF is never reached. A press accepted mid-dwell advances immediately and the next advance follows 10 cycles later.
- **Reset mid-auto:** i_rst=1 at dwell count 5 in R10 → OFF on that edge. With i_auto still 1 after release, R1 on the next edge, then R5 after 10 cycles.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - pushbutton/auto-dwell sequencer for the LED blinker rate configuration
module led_mode_sequencer #(
    parameter int unsigned c_DEBOUNCE_COUNT = 250000,
    parameter int unsigned c_DWELL_COUNT    = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_button,
    input  logic       i_auto,
    output logic       o_enable,
    output logic       o_select0,
    output logic       o_select1,
    output logic [2:0] o_mode
);

    localparam int unsigned DEB_W   = $clog2(c_DEBOUNCE_COUNT);
    localparam int unsigned DWELL_W = $clog2(c_DWELL_COUNT);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(c_DEBOUNCE_COUNT - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(c_DWELL_COUNT - 1);

    // Encoding doubles as the o_mode value, so o_mode is the state register itself.
    typedef enum logic [2:0] {
        ST_OFF = 3'd0,
        ST_R1  = 3'd1,
        ST_R5  = 3'd2,
        ST_R10 = 3'd3,
        ST_R20 = 3'd4
    } state_t;

    logic             s1_q, s2_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               enable_q;
    logic [1:0]         sel_q;

    // Rate-only successor: R20 wraps to R1, OFF is never produced.
    function automatic state_t next_rate(input state_t s);
        case (s)
            ST_R1:   return ST_R5;
            ST_R5:   return ST_R10;
            ST_R10:  return ST_R20;
            default: return ST_R1;
        endcase
    endfunction

    // Synchronizer, debounce and step-edge registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            s1_q       <= i_button;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    // Accept a new level only after it has differed from deb for the full count.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (s2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // One step per accepted press; releases produce nothing.
    assign step = deb_q & ~deb_prev_q;

    // Next state and dwell counter for manual and auto modes.
    always_comb begin
        state_d = state_q;
        dwell_d = '0;
        if (!i_auto) begin
            if (step) begin
                state_d = (state_q == ST_R20) ? ST_OFF
                        : (state_q == ST_OFF) ? ST_R1
                        : next_rate(state_q);
            end
        end else if (state_q == ST_OFF) begin
            state_d = ST_R1;
        end else if (step || dwell_q == DWELL_LAST) begin
            state_d = next_rate(state_q);
        end else begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    // State, dwell and output registers all load on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_OFF;
            dwell_q  <= '0;
            enable_q <= 1'b0;
            sel_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            enable_q <= (state_d != ST_OFF);
            sel_q    <= (state_d == ST_OFF) ? 2'b00 : 2'(state_d - ST_R1);
        end
    end

    assign o_mode    = state_q;
    assign o_enable  = enable_q;
    assign o_select0 = sel_q[0];
    assign o_select1 = sel_q[1];

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - scoreboard bench for led_mode_sequencer
module tb_led_mode_sequencer;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_button = 1'b0;
    logic       i_auto = 1'b0;
    logic       o_enable, o_select0, o_select1;
    logic [2:0] o_mode;

    typedef struct {
        int         cyc;
        logic [2:0] mode;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;
    bit         mon_en = 1'b0;
    logic [2:0] exp_mode = 3'd0;
    logic [2:0] prev_mode = 3'd0;
    int         t_r10 = 0;

    led_mode_sequencer #(
        .c_DEBOUNCE_COUNT(4),
        .c_DWELL_COUNT   (10)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_button (i_button),
        .i_auto   (i_auto),
        .o_enable (o_enable),
        .o_select0(o_select0),
        .o_select1(o_select1),
        .o_mode   (o_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] cfg_of(input logic [2:0] m);
        logic [1:0] s;
        s = 2'(m - 3'd1);
        return (m == 3'd0) ? 3'b000 : {1'b1, s};
    endfunction

    // Pop one expected event whenever o_mode changes; check enable/selects every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && o_mode !== prev_mode) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_change: o_mode %0d -> %0d at cycle %0d, none expected", prev_mode, o_mode, cyc);
            end else begin
                e = sb_q.pop_front();
                exp_mode = e.mode;
                tests_run++;
                if (o_mode !== e.mode) begin
                    tests_failed++;
                    $display("FAIL mode_value: got %0d expected %0d", o_mode, e.mode);
                end
                tests_run++;
                if (cyc !== e.cyc) begin
                    tests_failed++;
                    $display("FAIL mode_timing: mode %0d at cycle %0d expected cycle %0d", o_mode, cyc, e.cyc);
                end
            end
        end
        if (mon_en) begin
            tests_run++;
            if ({o_enable, o_select1, o_select0} !== cfg_of(exp_mode)) begin
                tests_failed++;
                $display("FAIL cfg_outputs: got %b expected %b (mode %0d) at cycle %0d",
                         {o_enable, o_select1, o_select0}, cfg_of(exp_mode), exp_mode, cyc);
            end
        end
        prev_mode = o_mode;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c, input logic [2:0] m);
        exp_t e;
        e.cyc  = c;
        e.mode = m;
        sb_q.push_back(e);
    endtask

    task automatic check_empty(input string name);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_pending: %0d expected events not seen, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_off(input string name);
        tests_run++;
        if ({o_enable, o_select1, o_select0, o_mode} !== 6'd0) begin
            tests_failed++;
            $display("FAIL %s: enable/sel1/sel0/mode = %b%b%b/%0d required 000/0",
                     name, o_enable, o_select1, o_select0, o_mode);
        end
    endtask

    task automatic press(input logic [2:0] m);
        push_exp(cyc + 7, m);
        i_button = 1'b1;
        repeat (6) tick();
        i_button = 1'b0;
        repeat (10) tick();
    endtask

    task automatic quiet_reset();
        mon_en = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
        exp_mode = 3'd0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            tick();
            check_off("reset_initial");
        end
        i_rst = 1'b0;
        i_auto = 1'b1;
        repeat ($urandom_range(3, 40)) tick();
        i_rst = 1'b1;
        repeat (2) begin
            tick();
            check_off("reset_held");
        end
        i_auto = 1'b0;
        i_rst = 1'b0;
        tick();
        check_off("reset_release");
        exp_mode = 3'd0;
        mon_en = 1'b1;
    endtask

    task automatic test_glitch();
        i_button = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            i_button = 1'b0;
            tick();
            i_button = 1'b1;
            tick();
        end
        i_button = 1'b0;
        repeat (12) tick();
        check_off("glitch_reject");
        check_empty("glitch");
    endtask

    task automatic test_manual_single();
        push_exp(cyc + 7, 3'd1);
        i_button = 1'b1;
        repeat (8) tick();
        i_button = 1'b0;
        repeat (12) tick();
        tests_run++;
        if (o_mode !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_press_hold: o_mode %0d required 1", o_mode);
        end
        check_empty("single_press");
    endtask

    task automatic test_manual_cycle();
        quiet_reset();
        press(3'd1);
        press(3'd2);
        press(3'd3);
        press(3'd4);
        press(3'd0);
        check_empty("manual_cycle");
        check_off("manual_wrap_off");
    endtask

    task automatic test_auto();
        int c0;
        c0 = cyc;
        i_auto = 1'b1;
        push_exp(c0 + 1, 3'd1);
        push_exp(c0 + 11, 3'd2);
        push_exp(c0 + 21, 3'd3);
        push_exp(c0 + 31, 3'd4);
        push_exp(c0 + 41, 3'd1);
        repeat (42) tick();
        press(3'd2);
        push_exp(c0 + 59, 3'd3);
        t_r10 = c0 + 59;
        repeat (3) tick();
        check_empty("auto_sequence");
    endtask

    task automatic test_reset_mid_auto();
        while (cyc < t_r10 + 5) tick();
        i_rst = 1'b1;
        push_exp(t_r10 + 6, 3'd0);
        push_exp(t_r10 + 7, 3'd1);
        push_exp(t_r10 + 17, 3'd2);
        tick();
        check_off("reset_mid_auto");
        i_rst = 1'b0;
        repeat (14) tick();
        check_empty("reset_mid_auto");
        i_auto = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_manual_single();
        test_manual_cycle();
        test_auto();
        test_reset_mid_auto();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
